alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_drv_pkg.sv | 24 ++
 rtl/alu_cmd_driver_if.sv | 46 ++++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_driver.sv | 127 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_drv_pkg.sv
// Shared types and defaults for the ALU command driver: opcode, FSM state,
// command record and default FIFO depth / settle time.
package alu_drv_pkg;

    typedef logic [2:0] opc_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResp
    } state_e;

    typedef struct packed {
        opc_t        opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
    } cmd_t;

    localparam int unsigned DefDepth  = 4;
    localparam int unsigned DefSettle = 1;
    localparam int unsigned CmdWidth  = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command, ALU-drive and response signals of the ALU command driver.
// slave is the driver's view; master is the environment (producer, ALU, consumer).
interface alu_cmd_driver_if;
    import alu_drv_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    opc_t        cmd_opc;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_c;

    opc_t        alu_opc;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c;
    logic [15:0] alu_w;
    logic        alu_zer;
    logic        alu_neg;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_w;
    logic        rsp_zer;
    logic        rsp_neg;
    logic [7:0]  ops_done;

    modport slave (
        input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c,
        input  alu_w, alu_zer, alu_neg,
        input  rsp_ready,
        output cmd_ready,
        output alu_opc, alu_a, alu_b, alu_c,
        output rsp_valid, rsp_w, rsp_zer, rsp_neg, ops_done
    );

    modport master (
        output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c,
        output alu_w, alu_zer, alu_neg,
        output rsp_ready,
        input  cmd_ready,
        input  alu_opc, alu_a, alu_b, alu_c,
        input  rsp_valid, rsp_w, rsp_zer, rsp_neg, ops_done
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; rdata shows the head entry
// combinationally so a pop and the use of its data share one edge.
module cmd_fifo
    import alu_drv_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned WIDTH = CmdWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Storage needs no reset: only entries counted as valid are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands, drives each one to the ALU for SETTLE cycles, then
// captures the result and holds it until the consumer takes it.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned SETTLE = DefSettle,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_driver_if.slave  bus
);

    localparam logic [2:0] SettleLoad = 3'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    cmd_t        alu_q, alu_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_w_q, rsp_w_d;
    logic        rsp_zer_q, rsp_zer_d;
    logic        rsp_neg_q, rsp_neg_d;
    logic [7:0]  ops_q, ops_d;

    cmd_t cmd_in, head;
    logic fifo_pop, fifo_full, fifo_empty;

    assign cmd_in = '{opc: bus.cmd_opc, a: bus.cmd_a, b: bus.cmd_b, c: bus.cmd_c};

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CmdWidth)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .wdata (cmd_in),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready = !fifo_full;
    assign bus.alu_opc   = alu_q.opc;
    assign bus.alu_a     = alu_q.a;
    assign bus.alu_b     = alu_q.b;
    assign bus.alu_c     = alu_q.c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_w     = rsp_w_q;
    assign bus.rsp_zer   = rsp_zer_q;
    assign bus.rsp_neg   = rsp_neg_q;
    assign bus.ops_done  = ops_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_d       = alu_q;
        rsp_valid_d = rsp_valid_q;
        rsp_w_d     = rsp_w_q;
        rsp_zer_d   = rsp_zer_q;
        rsp_neg_d   = rsp_neg_q;
        ops_d       = ops_q;
        fifo_pop    = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_d    = head;
                    cnt_d    = SettleLoad;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 3'd0) begin
                    rsp_w_d     = bus.alu_w;
                    rsp_zer_d   = bus.alu_zer;
                    rsp_neg_d   = bus.alu_neg;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_d       = ops_q + 8'd1;
                    // Back-to-back issue skips IDLE when work is already queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_d    = head;
                        cnt_d    = SettleLoad;
                        state_d  = StDrive;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            alu_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_w_q     <= 16'd0;
            rsp_zer_q   <= 1'b0;
            rsp_neg_q   <= 1'b0;
            ops_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_q       <= alu_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_w_q     <= rsp_w_d;
            rsp_zer_q   <= rsp_zer_d;
            rsp_neg_q   <= rsp_neg_d;
            ops_q       <= ops_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: SETTLE=1 and SETTLE=3 instances, each
// driving a stub adder ALU; inputs change and outputs are sampled on negedges.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_cmd_driver_if bif1 ();
    alu_cmd_driver_if bif2 ();

    assign bif1.alu_w   = bif1.alu_a + bif1.alu_b + {15'd0, bif1.alu_c};
    assign bif1.alu_zer = (bif1.alu_w == 16'd0);
    assign bif1.alu_neg = bif1.alu_w[15];
    assign bif2.alu_w   = bif2.alu_a + bif2.alu_b + {15'd0, bif2.alu_c};
    assign bif2.alu_zer = (bif2.alu_w == 16'd0);
    assign bif2.alu_neg = bif2.alu_w[15];

    alu_cmd_driver #(.SETTLE(1), .DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(bif1));
    alu_cmd_driver #(.SETTLE(3), .DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(bif2));

    typedef struct {
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] w;
        logic        zer;
        logic        neg;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_q [$];
        logic [15:0] exp_w;
        logic [15:0] first_a;
        logic [15:0] cur_w;
        int          got;
        int          spurious;
        int          sent;

        vecs[0] = '{3'd0, 16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{3'd2, 16'h8000, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{3'd5, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[4] = '{3'd7, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{3'd3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        bif1.cmd_valid = 0; bif1.cmd_opc = 0; bif1.cmd_a = 0; bif1.cmd_b = 0; bif1.cmd_c = 0;
        bif1.rsp_ready = 1;
        bif2.cmd_valid = 0; bif2.cmd_opc = 0; bif2.cmd_a = 0; bif2.cmd_b = 0; bif2.cmd_c = 0;
        bif2.rsp_ready = 1;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bif1.cmd_ready, 1);
        check("rst_rsp_valid", bif1.rsp_valid, 0);
        check("rst_alu_a", bif1.alu_a, 0);
        check("rst_ops_done", bif1.ops_done, 0);
        rst = 0;
        @(negedge clk);
        check("post_rst_cmd_ready", bif1.cmd_ready, 1);
        check("post_rst_rsp_w", bif1.rsp_w, 0);

        // Single-op latency and flags, one vector at a time
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("vec_cmd_ready", bif1.cmd_ready, 1);
            bif1.cmd_valid = 1; bif1.cmd_opc = vecs[i].opc;
            bif1.cmd_a = vecs[i].a; bif1.cmd_b = vecs[i].b; bif1.cmd_c = vecs[i].c;
            @(negedge clk);
            bif1.cmd_valid = 0;
            check("vec_early_valid", bif1.rsp_valid, 0);
            @(negedge clk);
            check("vec_alu_opc", bif1.alu_opc, vecs[i].opc);
            check("vec_alu_a", bif1.alu_a, vecs[i].a);
            check("vec_alu_b", bif1.alu_b, vecs[i].b);
            check("vec_alu_c", bif1.alu_c, vecs[i].c);
            check("vec_drive_valid", bif1.rsp_valid, 0);
            @(negedge clk);
            check("vec_rsp_valid", bif1.rsp_valid, 1);
            check("vec_rsp_w", bif1.rsp_w, vecs[i].w);
            check("vec_rsp_zer", bif1.rsp_zer, vecs[i].zer);
            check("vec_rsp_neg", bif1.rsp_neg, vecs[i].neg);
            @(negedge clk);
            check("vec_rsp_cleared", bif1.rsp_valid, 0);
            check("vec_ops_done", bif1.ops_done, i + 1);
        end

        // Backpressure: 5 commands with consumer stalled
        @(negedge clk);
        bif1.rsp_ready = 0;
        first_a = 16'h1000;
        for (int k = 0; k < 5; k++) begin
            check("bp_ready_before_push", bif1.cmd_ready, 1);
            bif1.cmd_valid = 1;
            bif1.cmd_opc   = 3'(k);
            bif1.cmd_a     = 16'(16'h1000 + k * 16'h0111);
            bif1.cmd_b     = 16'(k);
            bif1.cmd_c     = 1'(k % 2);
            exp_q.push_back(16'(16'h1000 + k * 16'h0111 + k + (k % 2)));
            @(negedge clk);
        end
        bif1.cmd_a = 16'hDEAD; bif1.cmd_b = 16'h0000; bif1.cmd_c = 0;
        for (int k = 0; k < 3; k++) begin
            check("bp_full", bif1.cmd_ready, 0);
            check("bp_rsp_valid_held", bif1.rsp_valid, 1);
            check("bp_rsp_w_held", bif1.rsp_w, exp_q[0]);
            check("bp_alu_a_held", bif1.alu_a, first_a);
            @(negedge clk);
        end
        bif1.cmd_valid = 0;
        bif1.rsp_ready = 1;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            if (bif1.rsp_valid) begin
                exp_w = exp_q.pop_front();
                check("bp_order_w", bif1.rsp_w, exp_w);
                got++;
            end
            @(negedge clk);
        end
        check("bp_resp_count", got, 5);
        check("bp_ops_done", bif1.ops_done, 11);
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif1.rsp_valid) spurious++;
        end
        check("bp_rejected_push", spurious, 0);

        // SETTLE=3 timing on the second instance
        @(negedge clk);
        bif2.cmd_valid = 1; bif2.cmd_opc = 3'd4;
        bif2.cmd_a = 16'h0010; bif2.cmd_b = 16'h0020; bif2.cmd_c = 1;
        @(negedge clk);
        bif2.cmd_valid = 0;
        check("s3_early_valid", bif2.rsp_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("s3_rsp_valid_timing", bif2.rsp_valid, (k == 4) ? 1 : 0);
            if (k <= 3) begin
                check("s3_alu_a_stable", bif2.alu_a, 16'h0010);
                check("s3_alu_b_stable", bif2.alu_b, 16'h0020);
            end else begin
                check("s3_rsp_w", bif2.rsp_w, 16'h0031);
            end
        end
        @(negedge clk);
        check("s3_ops_done", bif2.ops_done, 1);

        // Reset while DRIVE with two queued commands
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bif2.cmd_valid = 1; bif2.cmd_a = 16'(16'h0A00 + k); bif2.cmd_b = 16'h0001;
            bif2.cmd_c = 0; bif2.cmd_opc = 3'd6;
            @(negedge clk);
        end
        bif2.cmd_valid = 0;
        check("mid_drive_alu_a", bif2.alu_a, 16'h0A00);
        check("mid_drive_no_rsp", bif2.rsp_valid, 0);
        rst = 1;
        #1;
        check("arst_alu_a", bif2.alu_a, 0);
        check("arst_alu_opc", bif2.alu_opc, 0);
        check("arst_rsp_valid", bif2.rsp_valid, 0);
        check("arst_rsp_w", bif2.rsp_w, 0);
        check("arst_ops_done", bif2.ops_done, 0);
        check("arst_cmd_ready", bif2.cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (bif2.rsp_valid || bif1.rsp_valid || bif2.alu_a != 16'd0) spurious++;
        end
        check("arst_no_stale_rsp", spurious, 0);

        // 256 streamed ops: ops_done wraps, FIFO pointers wrap, order kept
        exp_q.delete();
        sent = 0; got = 0; cur_w = 0;
        for (int cyc = 0; cyc < 3000 && got < 256; cyc++) begin
            @(negedge clk);
            if (bif1.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("wrap_spurious", bif1.rsp_valid, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("wrap_order_w", bif1.rsp_w, exp_w);
                    got++;
                end
            end
            if (bif1.cmd_valid && bif1.cmd_ready) begin
                exp_q.push_back(cur_w);
                sent++;
            end
            if (sent < 256) begin
                bif1.cmd_valid = 1;
                bif1.cmd_opc   = 3'(sent);
                bif1.cmd_a     = 16'(sent * 257);
                bif1.cmd_b     = 16'(16'hF00F ^ sent);
                bif1.cmd_c     = 1'(sent % 2);
                cur_w = 16'(16'(sent * 257) + 16'(16'hF00F ^ sent) + (sent % 2));
            end else begin
                bif1.cmd_valid = 0;
            end
        end
        @(negedge clk);
        check("wrap_resp_count", got, 256);
        check("wrap_ops_done", bif1.ops_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
